// File: rtl/jtbubl_pkg.sv
// Shared definitions for the jtbubl colour mixer: palette geometry, colour width
// and unpacking of a {hi, lo} palette entry into 4-bit R/G/B.
package jtbubl_pkg;

    localparam int PAL_AW    = 8;
    localparam int CPU_AW    = 9;
    localparam int COLOR_W   = 4;
    localparam int BLANK_DLY = 2;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // hi = RRRRGGGG, lo_hi = upper nibble of the odd byte (BBBB)
    function automatic rgb_t unpack_rgb(input logic [7:0] hi, input logic [COLOR_W-1:0] lo_hi);
        rgb_t c;
        c.r = hi[7:4];
        c.g = hi[3:0];
        c.b = lo_hi;
        return c;
    endfunction

endpackage

// File: rtl/jtbubl_colmix_if.sv
// CPU-side palette bus of the colour mixer: chip select, direction, address,
// write data and registered read data.
interface jtbubl_colmix_if;
    import jtbubl_pkg::*;

    logic              pal_cs;
    logic              cpu_rnw;
    logic [CPU_AW-1:0] cpu_addr;
    logic [7:0]        cpu_dout;
    logic [7:0]        pal_dout;

    modport master (output pal_cs, cpu_rnw, cpu_addr, cpu_dout, input pal_dout);
    modport slave  (input pal_cs, cpu_rnw, cpu_addr, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtbubl_pal_ram.sv
// 256x8 dual-port palette RAM, single clock, read-before-write. Port A is the
// CPU read/write side, port B is the read-only video side.
module jtbubl_pal_ram
    import jtbubl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic              rd_a,
    input  logic [PAL_AW-1:0] addr_a,
    input  logic [7:0]        din_a,
    output logic [7:0]        q_a,
    input  logic              en_b,
    input  logic [PAL_AW-1:0] addr_b,
    output logic [7:0]        q_b
);

    logic [7:0] mem [0:(1<<PAL_AW)-1];

    // Contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
    end

    // Both reads sample the array before this edge's write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (rd_a) q_a <= mem[addr_a];
            if (en_b) q_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/jtbubl_colmix.sv
// Palette lookup and blanking for the final video stage, two pxl_cen periods deep.
// Optional macro JTBUBL_GRAY_EN replaces the colour output with a grey level.
module jtbubl_colmix
    import jtbubl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pxl_cen,
    input  logic               LHBL,
    input  logic               LVBL,
    input  logic [PAL_AW-1:0]  col_addr,
    jtbubl_colmix_if.slave     cpu,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               LHBL_dly,
    output logic               LVBL_dly
);

    logic              cpu_wr, cpu_rd, sel_lo;
    logic [7:0]        hi_qa, lo_qa, hi_q_p1, lo_q_p1;
    logic [PAL_AW-1:0] idx_p0;
    logic [1:0]        blank_p0, blank_p1;   // {LHBL, LVBL}
    rgb_t              pix_p1, out_c;
    logic              unused_lo;

    assign cpu_wr = cpu.pal_cs & ~cpu.cpu_rnw;
    assign cpu_rd = cpu.pal_cs &  cpu.cpu_rnw;

    jtbubl_pal_ram u_hi (
        .clk(clk), .rst(rst),
        .we_a(cpu_wr & ~cpu.cpu_addr[0]), .rd_a(cpu_rd),
        .addr_a(cpu.cpu_addr[CPU_AW-1:1]), .din_a(cpu.cpu_dout), .q_a(hi_qa),
        .en_b(pxl_cen), .addr_b(idx_p0), .q_b(hi_q_p1)
    );

    jtbubl_pal_ram u_lo (
        .clk(clk), .rst(rst),
        .we_a(cpu_wr & cpu.cpu_addr[0]), .rd_a(cpu_rd),
        .addr_a(cpu.cpu_addr[CPU_AW-1:1]), .din_a(cpu.cpu_dout), .q_a(lo_qa),
        .en_b(pxl_cen), .addr_b(idx_p0), .q_b(lo_q_p1)
    );

    // Byte select follows the last read, so pal_dout holds between reads
    always_ff @(posedge clk) begin
        if (rst)         sel_lo <= 1'b0;
        else if (cpu_rd) sel_lo <= cpu.cpu_addr[0];
    end
    assign cpu.pal_dout = sel_lo ? lo_qa : hi_qa;

    // Low nibble of the odd byte is CPU storage only
    assign unused_lo = ^lo_q_p1[3:0];
    assign pix_p1    = unpack_rgb(hi_q_p1, lo_q_p1[7:4]);

`ifdef JTBUBL_GRAY_EN
    function automatic logic [COLOR_W-1:0] to_gray(input rgb_t c);
        logic [5:0] s;
        s = {2'b00, c.r} + {1'b0, c.g, 1'b0} + {2'b00, c.b};
        return s[5:2];
    endfunction

    logic [COLOR_W-1:0] gray;
    always_comb begin
        gray  = to_gray(pix_p1);
        out_c = {gray, gray, gray};
    end
`else
    assign out_c = pix_p1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_p0   <= '0;
            blank_p0 <= '0;
            blank_p1 <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            // S0: sample palette index and blanking
            idx_p0   <= col_addr;
            blank_p0 <= {LHBL, LVBL};
            // S1: RAM port B registers the entry; blanking follows
            blank_p1 <= blank_p0;
            // S2: colour out, forced black during either blank
            {LHBL_dly, LVBL_dly} <= blank_p1;
            if (&blank_p1) {red, green, blue} <= out_c;
            else           {red, green, blue} <= '0;
        end
    end

endmodule

// File: tb/tb_jtbubl_colmix.sv
// Directed bench for jtbubl_colmix: CPU palette access, pixel latency, blanking,
// read/write collision and reset behaviour (expectations follow JTBUBL_GRAY_EN).
module tb_jtbubl_colmix;
    import jtbubl_pkg::*;

`ifdef JTBUBL_GRAY_EN
    localparam logic [11:0] E8   = 12'h555;  // (10+10+3)>>2 = 5
    localparam logic [11:0] E255 = 12'h222;  // (1+4+3)>>2 = 2
    localparam logic [11:0] E1   = 12'h333;  // (15+0+0)>>2 = 3
    localparam logic [11:0] E8F  = 12'hCCC;  // (15+30+3)>>2 = 12
`else
    localparam logic [11:0] E8   = 12'hA53;
    localparam logic [11:0] E255 = 12'h123;
    localparam logic [11:0] E1   = 12'hF00;
    localparam logic [11:0] E8F  = 12'hFF3;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               pxl_cen;
    logic               LHBL, LVBL;
    logic [PAL_AW-1:0]  col_addr;
    logic [COLOR_W-1:0] red, green, blue;
    logic               LHBL_dly, LVBL_dly;
    int                 total = 0;
    int                 bad   = 0;

    jtbubl_colmix_if bus ();

    jtbubl_colmix dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .col_addr(col_addr), .cpu(bus.slave),
        .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [8:0] addr, input logic [7:0] data);
        bus.pal_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = addr; bus.cpu_dout = data;
        tick();
        bus.pal_cs = 1'b0; bus.cpu_rnw = 1'b1;
    endtask

    task automatic cpu_rd(input string tag, input logic [8:0] addr, input logic [7:0] exp);
        bus.pal_cs = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = addr;
        tick();
        bus.pal_cs = 1'b0;
        check(tag, {8'h00, bus.pal_dout}, {8'h00, exp});
    endtask

    // One pixel: a single-clk pxl_cen pulse, then two idle clocks
    task automatic pix(input logic [7:0] col, input logic h, input logic v);
        col_addr = col; LHBL = h; LVBL = v; pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_px(input string tag, input logic [11:0] rgb, input logic h, input logic v);
        check({tag, "_rgb"}, {4'h0, red, green, blue}, {4'h0, rgb});
        check({tag, "_hbl"}, {15'h0, LHBL_dly}, {15'h0, h});
        check({tag, "_vbl"}, {15'h0, LVBL_dly}, {15'h0, v});
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; col_addr = 8'h00;
        bus.pal_cs = 1'b0; bus.cpu_rnw = 1'b1; bus.cpu_addr = '0; bus.cpu_dout = '0;
        tick(); tick(); tick();
        chk_px("reset", 12'h000, 1'b0, 1'b0);
        check("reset_pal_dout", {8'h00, bus.pal_dout}, 16'h0000);
        rst = 1'b0;
        tick();

        // Entry 8 = {A5, 3C}, entry 255 = {12, 34}, entry 1 = {F0, 00}
        cpu_wr(9'h010, 8'hA5);
        cpu_wr(9'h011, 8'h3C);
        cpu_wr(9'h1FE, 8'h12);
        cpu_wr(9'h1FF, 8'h34);
        cpu_wr(9'h002, 8'hF0);
        cpu_wr(9'h003, 8'h00);
        cpu_rd("rd_010", 9'h010, 8'hA5);
        cpu_rd("rd_011", 9'h011, 8'h3C);
        tick();
        check("rd_hold", {8'h00, bus.pal_dout}, 16'h003C);

        // Output lags the sampled index by two pixels
        pix(8'h08, 1, 1); chk_px("p1", 12'h000, 1'b0, 1'b0);
        pix(8'h08, 1, 1); chk_px("p2", 12'h000, 1'b0, 1'b0);
        pix(8'hFF, 1, 1); chk_px("p3", E8, 1'b1, 1'b1);
        tick();
        check("p3_hold", {4'h0, red, green, blue}, {4'h0, E8});
        pix(8'h01, 1, 1); chk_px("p4", E8, 1'b1, 1'b1);
        pix(8'h08, 0, 1); chk_px("p5", E255, 1'b1, 1'b1);
        pix(8'h08, 1, 1); chk_px("p6", E1, 1'b1, 1'b1);
        pix(8'h08, 1, 0); chk_px("p7_hblank", 12'h000, 1'b0, 1'b1);
        pix(8'h08, 1, 1); chk_px("p8", E8, 1'b1, 1'b1);
        pix(8'h08, 1, 1); chk_px("p9_vblank", 12'h000, 1'b1, 1'b0);
        pix(8'h08, 1, 1); chk_px("p10", E8, 1'b1, 1'b1);

        // p12's pxl_cen edge is both the S1 read of p11 and a CPU write to entry 8 hi
        pix(8'h08, 1, 1); chk_px("p11", E8, 1'b1, 1'b1);
        col_addr = 8'h08; LHBL = 1'b1; LVBL = 1'b1; pxl_cen = 1'b1;
        bus.pal_cs = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 9'h010; bus.cpu_dout = 8'hFF;
        tick();
        pxl_cen = 1'b0; bus.pal_cs = 1'b0; bus.cpu_rnw = 1'b1;
        tick(); tick();
        chk_px("p12", E8, 1'b1, 1'b1);
        pix(8'h08, 1, 1); chk_px("p13_old", E8, 1'b1, 1'b1);
        pix(8'h08, 1, 1); chk_px("p14_new", E8F, 1'b1, 1'b1);

        // Restore entry 8, then reset mid-stream
        cpu_wr(9'h010, 8'hA5);
        cpu_rd("rd_restore", 9'h011, 8'h3C);
        pix(8'h08, 1, 1);
        pix(8'h08, 1, 1);
        rst = 1'b1;
        pix(8'h08, 1, 1);
        chk_px("rst_mid", 12'h000, 1'b0, 1'b0);
        check("rst_pal_dout", {8'h00, bus.pal_dout}, 16'h0000);
        pix(8'h08, 1, 1);
        chk_px("rst_hold", 12'h000, 1'b0, 1'b0);
        rst = 1'b0;
        pix(8'h08, 1, 1); chk_px("rel1", 12'h000, 1'b0, 1'b0);
        pix(8'h08, 1, 1); chk_px("rel2", 12'h000, 1'b0, 1'b0);
        pix(8'h08, 1, 1); chk_px("rel3", E8, 1'b1, 1'b1);
        cpu_rd("rd_after_rst", 9'h010, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
